arb_mux: RTL and testbench



---
 rtl/arb_mux.sv | 137 +++++++++++++
 tb/tb_arb_mux.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux.sv
// arb_mux: round-robin N-channel arbitrating mux with a one-deep registered output stage.
// Latency: 1 cycle from the accepting edge to out_valid/out_data; 1 beat/cycle sustained.
// Backpressure: refills on the same edge it drains; while out_valid & !out_ready every in_ready is 0.
// Optional packet locking is compiled in when ARB_MUX_LOCK_EN is defined.
module arb_mux #(
  parameter int WIDTH  = 32,
  parameter int INPUTS = 4,
  parameter int WSEL   = $clog2(INPUTS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH*INPUTS-1:0] in_data,
  input  logic [INPUTS-1:0]       in_valid,
  input  logic [INPUTS-1:0]       in_last,
  output logic [INPUTS-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [WSEL-1:0]         out_sel,
  input  logic                    out_ready
);

  typedef struct packed {
    logic [WIDTH-1:0] dat;
    logic             last;
    logic [WSEL-1:0]  sel;
  } beat_t;

  beat_t             out_q;
  beat_t             beat_d;
  logic              out_vld_q;
  logic [WSEL-1:0]   ptr_q;
  logic [WSEL-1:0]   grant;
  logic              grant_vld;
  logic              load_en;
  logic              accept;
  logic [INPUTS-1:0] req;

  // Channel index base+off, wrapped explicitly at INPUTS so a non-power-of-two
  // channel count never produces an index beyond the last real channel.
  function automatic logic [WSEL-1:0] wrap_add(input logic [WSEL-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= INPUTS) s = s - INPUTS;
    return s[WSEL-1:0];
  endfunction

`ifdef ARB_MUX_LOCK_EN
  logic            lock_q;
  logic [WSEL-1:0] lock_ch_q;

  // While a packet is in flight only its owner may compete, even when idle
  always_comb begin
    req = in_valid;
    if (lock_q) begin
      req            = '0;
      req[lock_ch_q] = in_valid[lock_ch_q];
    end
  end
`else
  assign req = in_valid;
`endif

  assign load_en = !out_vld_q || out_ready;

  // Round-robin scan from ptr; descending loop so the smallest offset wins
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int i = INPUTS - 1; i >= 0; i--) begin
      if (req[wrap_add(ptr_q, i)]) begin
        grant     = wrap_add(ptr_q, i);
        grant_vld = 1'b1;
      end
    end
  end

  assign accept = !reset && load_en && grant_vld;

  // One-hot ready toward the granted channel only; silent during reset
  always_comb begin
    in_ready = '0;
    if (accept) in_ready[grant] = 1'b1;
  end

  // Beat presented by the granted channel
  always_comb begin
    beat_d      = '0;
    beat_d.dat  = in_data[int'(grant)*WIDTH +: WIDTH];
    beat_d.last = in_last[grant];
    beat_d.sel  = grant;
  end

  // Output register: load on accept, otherwise drop valid once drained
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (accept) begin
      out_q     <= beat_d;
      out_vld_q <= 1'b1;
    end else if (out_ready) begin
      out_vld_q <= 1'b0;
    end
  end

`ifdef ARB_MUX_LOCK_EN
  // Pointer moves only at packet end; a non-last beat locks onto its channel
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else if (accept) begin
      if (in_last[grant]) begin
        ptr_q  <= wrap_add(grant, 1);
        lock_q <= 1'b0;
      end else begin
        lock_q    <= 1'b1;
        lock_ch_q <= grant;
      end
    end
  end
`else
  // Per-beat arbitration: pointer moves past every granted channel
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else if (accept) ptr_q <= wrap_add(grant, 1);
  end
`endif

  assign out_data  = out_q.dat;
  assign out_last  = out_q.last;
  assign out_sel   = out_q.sel;
  assign out_valid = out_vld_q;

endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: scoreboard bench for arb_mux (4 channels) plus a 3-channel instance for wrap.
// Latency: expects each accepted beat on the output one edge after acceptance.
// Backpressure: drives out_ready low for a stall window and checks nothing moves.
module tb_arb_mux;

  typedef struct {
    logic [31:0] dat;
    logic        last;
    logic [1:0]  sel;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dat [4];
  logic [127:0] in_data;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_last = '0;
  logic [3:0]  in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic [1:0]  out_sel;
  logic        out_ready = 1'b1;

  logic [95:0] in_data3 = '0;
  logic [2:0]  in_valid3 = '0;
  logic [2:0]  in_last3 = 3'b111;
  logic [2:0]  in_ready3;
  logic [31:0] out_data3;
  logic        out_valid3;
  logic        out_last3;
  logic [1:0]  out_sel3;

  exp_t        src_q [4][$];
  exp_t        exp_q [$];
  exp_t        mon_e;
  logic [3:0]  acc_s = '0;
  int          checks = 0;
  int          failures = 0;

  assign in_data = {dat[3], dat[2], dat[1], dat[0]};

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(32), .INPUTS(4)) u_dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  arb_mux #(.WIDTH(32), .INPUTS(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_last(out_last3), .out_sel(out_sel3),
    .out_ready(1'b1)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic src(input int ch, input logic [31:0] d, input logic l);
    exp_t b;
    b.dat = d; b.last = l; b.sel = 2'(ch);
    src_q[ch].push_back(b);
  endtask

  task automatic expect_beat(input int ch, input logic [31:0] d, input logic l);
    exp_t b;
    b.dat = d; b.last = l; b.sel = 2'(ch);
    exp_q.push_back(b);
  endtask

  // Present the head of each source queue
  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() > 0) begin
        in_valid[i] = 1'b1;
        dat[i]      = src_q[i][0].dat;
        in_last[i]  = src_q[i][0].last;
      end else begin
        in_valid[i] = 1'b0;
      end
    end
  endtask

  // Advance one edge, retiring beats that handshook at the preceding negedge
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (acc_s[i]) void'(src_q[i].pop_front());
    drive();
  endtask

  always @(negedge clk) acc_s = in_valid & in_ready;

  // Scoreboard: every beat leaving the DUT must match the next expectation
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_beat", out_valid, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_out_sel", out_sel, mon_e.sel);
        check("sb_out_data", out_data, mon_e.dat);
        check("sb_out_last", out_last, mon_e.last);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) dat[i] = '0;

    // Reset with every channel requesting
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) src(i, 32'h1000_0000 * (i + 1) + k, 1'b1);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) expect_beat(i, 32'h1000_0000 * (i + 1) + k, 1'b1);
    drive();
    @(negedge clk);
    check("rst_in_ready", in_ready, 4'b0000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_sel", out_sel, 2'd0);
    check("rst_out_last", out_last, 1'b0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("first_grant", in_ready, 4'b0001);

    // Round robin, full throughput
    for (int n = 0; n < 8; n++) begin
      step();
      @(negedge clk);
      check("rr_out_valid", out_valid, 1'b1);
    end
    step();
    @(negedge clk);
    check("rr_drain_valid", out_valid, 1'b0);
    check("rr_all_seen", exp_q.size(), 0);

    // Backpressure: hold DEADBEEF for 5 stalled cycles
    out_ready = 1'b0;
    src(1, 32'hDEAD_BEEF, 1'b1);
    src(2, 32'hCAFE_F00D, 1'b1);
    expect_beat(1, 32'hDEAD_BEEF, 1'b1);
    expect_beat(2, 32'hCAFE_F00D, 1'b1);
    drive();
    step();
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_out_data", out_data, 32'hDEAD_BEEF);
      check("bp_out_sel", out_sel, 2'd1);
      check("bp_in_ready", in_ready, 4'b0000);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", in_ready, 4'b0100);
    step();
    @(negedge clk);
    check("bp_refill_valid", out_valid, 1'b1);
    step();
    @(negedge clk);
    check("drain_valid", out_valid, 1'b0);
    check("drain_hold_data", out_data, 32'hCAFE_F00D);
    check("drain_hold_sel", out_sel, 2'd2);

    // Packet from channel 1 competing with channel 2
    src(1, 32'h1100_0000, 1'b0);
    src(1, 32'h1100_0001, 1'b0);
    src(1, 32'h1100_0002, 1'b1);
    src(2, 32'h2200_0000, 1'b1);
    src(2, 32'h2200_0001, 1'b1);
`ifdef ARB_MUX_LOCK_EN
    expect_beat(1, 32'h1100_0000, 1'b0);
    expect_beat(1, 32'h1100_0001, 1'b0);
    expect_beat(1, 32'h1100_0002, 1'b1);
    expect_beat(2, 32'h2200_0000, 1'b1);
    expect_beat(2, 32'h2200_0001, 1'b1);
`else
    expect_beat(1, 32'h1100_0000, 1'b0);
    expect_beat(2, 32'h2200_0000, 1'b1);
    expect_beat(1, 32'h1100_0001, 1'b0);
    expect_beat(2, 32'h2200_0001, 1'b1);
    expect_beat(1, 32'h1100_0002, 1'b1);
`endif
    drive();
    for (int n = 0; n < 5; n++) begin
      step();
      @(negedge clk);
      check("pkt_out_valid", out_valid, 1'b1);
    end
    step();
    @(negedge clk);
    check("pkt_all_seen", exp_q.size(), 0);

    // Reset mid-packet with a beat held under backpressure
    out_ready = 1'b0;
    src(1, 32'hA5A5_0001, 1'b0);
    drive();
    step();
    @(negedge clk);
    check("mid_held_data", out_data, 32'hA5A5_0001);
    step();
    reset = 1'b1;
    src(1, 32'hB0B0_0001, 1'b1);
    src(3, 32'hC0C0_0003, 1'b1);
    drive();
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 4'b0000);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    expect_beat(1, 32'hB0B0_0001, 1'b1);
    expect_beat(3, 32'hC0C0_0003, 1'b1);
    @(negedge clk);
    check("mid_discard_valid", out_valid, 1'b0);
    check("mid_discard_data", out_data, 32'h0);
    check("mid_post_grant", in_ready, 4'b0010);
    for (int n = 0; n < 2; n++) begin
      step();
      @(negedge clk);
      check("mid_out_valid", out_valid, 1'b1);
    end
    step();
    @(negedge clk);
    check("mid_all_seen", exp_q.size(), 0);

    // Three channels: wrap from channel 2 back to channel 0
    in_data3  = {32'h0000_0032, 32'h0000_0031, 32'h0000_0030};
    in_valid3 = 3'b100;
    @(negedge clk);
    check("w3_first_grant", in_ready3, 3'b100);
    @(posedge clk);
    #1;
    in_valid3 = 3'b101;
    @(negedge clk);
    check("w3_sel_2", out_sel3, 2'd2);
    check("w3_data_2", out_data3, 32'h0000_0032);
    check("w3_wrap_grant", in_ready3, 3'b001);
    @(posedge clk);
    #1;
    in_valid3 = 3'b100;
    @(negedge clk);
    check("w3_sel_0", out_sel3, 2'd0);
    check("w3_data_0", out_data3, 32'h0000_0030);
    check("w3_next_grant", in_ready3, 3'b100);
    @(posedge clk);
    #1;
    in_valid3 = 3'b000;
    @(negedge clk);
    check("w3_sel_2b", out_sel3, 2'd2);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("w3_drain", out_valid3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
